// File: rtl/execute_mdu_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface execute_mdu_if #(
    parameter int unsigned XLEN = 64
) ();
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic            word;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, word, a, b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, word, a, b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/execute_mdu.sv
// Iterative RV64M multiply/divide: radix-2 shift-add multiply, restoring divide, one bit per cycle.
module execute_mdu #(
    parameter int unsigned XLEN         = 64,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input logic          clk,
    input logic          resetn,
    execute_mdu_if.slave mdu
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [6:0] W_FULL = 7'(XLEN);

    logic [1:0]        r_state;
    logic [6:0]        r_cnt;
    logic [2:0]        r_op;
    logic              r_word;
    logic              r_neg;
    logic              r_spec;
    logic [2*XLEN-1:0] r_prod;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_q;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_result;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Operand preparation at accept time
    logic            w_is_div, w_a_sen, w_b_sen, w_sa, w_sb, w_divz, w_ovf, w_special, w_neg;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_mag_a, w_mag_b, w_min, w_dvd, w_spec_res;

    always_comb begin
        w_is_div = mdu.op[2];
        w_a_sen  = w_is_div ? ~mdu.op[0] : (mdu.op != 3'd3);
        w_b_sen  = w_is_div ? ~mdu.op[0] : ~mdu.op[1];
        w_a_ext  = mdu.word ? (w_a_sen ? sext32(mdu.a[31:0]) : XLEN'(mdu.a[31:0])) : mdu.a;
        w_b_ext  = mdu.word ? (w_b_sen ? sext32(mdu.b[31:0]) : XLEN'(mdu.b[31:0])) : mdu.b;
        w_sa     = w_a_sen & w_a_ext[XLEN-1];
        w_sb     = w_b_sen & w_b_ext[XLEN-1];
        w_mag_a  = w_sa ? -w_a_ext : w_a_ext;
        w_mag_b  = w_sb ? -w_b_ext : w_b_ext;
        // Word dividends are pre-aligned so the restoring loop always consumes from the MSB
        w_dvd    = mdu.word ? (w_mag_a << (XLEN - 32)) : w_mag_a;
        w_min    = mdu.word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        w_divz   = (w_b_ext == '0);
        w_ovf    = ~mdu.op[0] & (w_a_ext == w_min) & (w_b_ext == '1);
        w_special = FAST_SPECIAL && w_is_div && (w_divz || w_ovf);
        if (!w_is_div)      w_neg = w_sa ^ w_sb;
        else if (mdu.op[1]) w_neg = w_sa;
        else                w_neg = (w_sa ^ w_sb) & ~w_divz;
        if (mdu.op[1])      w_spec_res = w_divz ? (mdu.word ? sext32(mdu.a[31:0]) : mdu.a) : '0;
        else                w_spec_res = w_divz ? '1 : w_min;
    end

    // One iteration of each datapath plus the finished result it would produce
    logic [2*XLEN-1:0] w_prod_d, w_pfin;
    logic [XLEN:0]     w_rem_sh, w_diff;
    logic [XLEN-1:0]   w_q_d, w_rem_d, w_dsel, w_dfin, w_fin;

    always_comb begin
        w_prod_d = r_prod + (r_q[0] ? r_mcand : '0);
        w_pfin   = r_neg ? -w_prod_d : w_prod_d;
        w_rem_sh = {r_rem, r_q[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_dvs};
        w_q_d    = {r_q[XLEN-2:0], ~w_diff[XLEN]};
        w_rem_d  = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
        w_dsel   = r_op[1] ? w_rem_d : w_q_d;
        w_dfin   = r_neg ? -w_dsel : w_dsel;
        if (r_state == S_MUL) begin
            if (r_word)               w_fin = sext32(w_pfin[31:0]);
            else if (r_op[1:0] == 0)  w_fin = w_pfin[XLEN-1:0];
            else                      w_fin = w_pfin[2*XLEN-1:XLEN];
        end else begin
            w_fin = r_word ? sext32(w_dfin[31:0]) : w_dfin;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_word   <= 1'b0;
            r_neg    <= 1'b0;
            r_spec   <= 1'b0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_result <= '0;
        end else if (mdu.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mdu.in_valid) begin
                        r_op    <= mdu.op;
                        r_word  <= mdu.word;
                        r_neg   <= w_neg;
                        r_spec  <= w_special;
                        r_prod  <= '0;
                        r_mcand <= {{XLEN{1'b0}}, w_mag_a};
                        r_q     <= w_is_div ? w_dvd : w_mag_b;
                        r_rem   <= '0;
                        r_dvs   <= w_mag_b;
                        // Special cases take a single pass through DIV with the answer preloaded
                        r_cnt   <= w_special ? 7'd1 : (mdu.word ? 7'd32 : W_FULL);
                        r_state <= w_is_div ? S_DIV : S_MUL;
                        if (w_special) r_result <= w_spec_res;
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_state == S_MUL) begin
                        r_prod  <= w_prod_d;
                        r_mcand <= r_mcand << 1;
                        r_q     <= r_q >> 1;
                    end else begin
                        r_q   <= w_q_d;
                        r_rem <= w_rem_d;
                    end
                    r_cnt <= r_cnt - 7'd1;
                    if (r_cnt == 7'd1) begin
                        r_state <= S_DONE;
                        if (!r_spec) r_result <= w_fin;
                    end
                end
                S_DONE: begin
                    if (mdu.out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mdu.in_ready  = (r_state == S_IDLE);
    assign mdu.out_valid = (r_state == S_DONE);
    assign mdu.busy      = (r_state == S_MUL) || (r_state == S_DIV);
    assign mdu.result    = r_result;
endmodule

// File: tb/tb_execute_mdu.sv
// Directed bench for execute_mdu: vector table of RV64M ops plus flush, backpressure and reset sequences.
module tb_execute_mdu;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid_f, in_valid_s, flush, out_ready, word, sel_slow;
    logic [2:0]  op;
    logic [63:0] a, b;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    execute_mdu_if #(.XLEN(64)) mi_f ();
    execute_mdu_if #(.XLEN(64)) mi_s ();

    assign mi_f.in_valid  = in_valid_f;
    assign mi_f.op        = op;
    assign mi_f.word      = word;
    assign mi_f.a         = a;
    assign mi_f.b         = b;
    assign mi_f.flush     = flush;
    assign mi_f.out_ready = out_ready;
    assign mi_s.in_valid  = in_valid_s;
    assign mi_s.op        = op;
    assign mi_s.word      = word;
    assign mi_s.a         = a;
    assign mi_s.b         = b;
    assign mi_s.flush     = flush;
    assign mi_s.out_ready = out_ready;

    execute_mdu #(.XLEN(64), .FAST_SPECIAL(1'b1)) dut_f (.clk(clk), .resetn(resetn), .mdu(mi_f));
    execute_mdu #(.XLEN(64), .FAST_SPECIAL(1'b0)) dut_s (.clk(clk), .resetn(resetn), .mdu(mi_s));

    logic        ov, rdy, bsy;
    logic [63:0] res;
    assign ov  = sel_slow ? mi_s.out_valid : mi_f.out_valid;
    assign rdy = sel_slow ? mi_s.in_ready  : mi_f.in_ready;
    assign bsy = sel_slow ? mi_s.busy      : mi_f.busy;
    assign res = sel_slow ? mi_s.result    : mi_f.result;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        logic        slow;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic [2:0] o, input logic w,
                                input logic [63:0] va, input logic [63:0] vb,
                                input logic [63:0] e, input int l, input logic s);
        vec_t v;
        v.name = nm; v.op = o; v.word = w; v.a = va; v.b = vb; v.exp = e; v.lat = l; v.slow = s;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v);
        int   n;
        logic bad_iter;
        sel_slow = v.slow;
        @(negedge clk);
        n = 0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({v.name, "_ready"}, 64'(rdy), 64'd1);
        op = v.op; word = v.word; a = v.a; b = v.b;
        if (v.slow) in_valid_s = 1'b1;
        else        in_valid_f = 1'b1;
        @(posedge clk);
        #1;
        in_valid_f = 1'b0;
        in_valid_s = 1'b0;
        // Operands must have been captured at accept
        a = ~v.a; b = ~v.b; op = ~v.op;
        n = 0;
        bad_iter = 1'b0;
        while (!ov && n < 200) begin
            if (!bsy || rdy) bad_iter = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk({v.name, "_latency"}, 64'(n), 64'(v.lat));
        chk({v.name, "_busy"}, 64'(bad_iter), 64'd0);
        chk({v.name, "_result"}, res, v.exp);
    endtask

    initial begin
        int   n;
        logic seen;
        resetn = 1'b0; in_valid_f = 1'b0; in_valid_s = 1'b0; flush = 1'b0; out_ready = 1'b1;
        word = 1'b0; op = 3'd0; a = '0; b = '0; sel_slow = 1'b0;
        #12;
        chk("reset_in_ready", 64'(rdy), 64'd1);
        chk("reset_out_valid", 64'(ov), 64'd0);
        chk("reset_busy", 64'(bsy), 64'd0);
        chk("reset_result", res, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        vecs.push_back(mk("mul", 0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 0));
        vecs.push_back(mk("mulhu", 3, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0));
        vecs.push_back(mk("mulh", 1, 0, '1, '1, 64'd0, 64, 0));
        vecs.push_back(mk("mulhsu", 2, 0, '1, 64'd2, '1, 64, 0));
        vecs.push_back(mk("mulh_neg", 1, 0, -64'sd5, 64'd3, '1, 64, 0));
        vecs.push_back(mk("mul_big", 0, 0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 64, 0));
        vecs.push_back(mk("mulhu_big", 3, 0, 64'h1_0000_0001, 64'h1_0000_0001, 64'd1, 64, 0));
        vecs.push_back(mk("mulw_pos", 0, 1, 64'hDEAD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 0));
        vecs.push_back(mk("mulw_neg", 0, 1, 64'h0000_0000_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 32, 0));
        vecs.push_back(mk("div", 4, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 0));
        vecs.push_back(mk("rem", 6, 0, -64'sd7, 64'd2, '1, 64, 0));
        vecs.push_back(mk("div_nn", 4, 0, -64'sd8, -64'sd3, 64'd2, 64, 0));
        vecs.push_back(mk("rem_nn", 6, 0, -64'sd8, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFE, 64, 0));
        vecs.push_back(mk("divu", 5, 0, 64'd100, 64'd7, 64'd14, 64, 0));
        vecs.push_back(mk("remu", 7, 0, 64'd100, 64'd7, 64'd2, 64, 0));
        vecs.push_back(mk("divuw", 5, 1, 64'h1_0000_0010, 64'd4, 64'd4, 32, 0));
        vecs.push_back(mk("divw", 4, 1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
                          64'hFFFF_FFFF_FFFF_FFFD, 32, 0));
        vecs.push_back(mk("remuw", 7, 1, 64'hFFFF_FFFF_0000_000B, 64'h5_0000_0003, 64'd2, 32, 0));
        vecs.push_back(mk("div_z", 4, 0, 64'd5, 64'd0, '1, 1, 0));
        vecs.push_back(mk("rem_z", 6, 0, 64'd5, 64'd0, 64'd5, 1, 0));
        vecs.push_back(mk("div_ovf", 4, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0));
        vecs.push_back(mk("rem_ovf", 6, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0));
        vecs.push_back(mk("divw_ovf", 4, 1, 64'h1_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0));
        vecs.push_back(mk("remw_ovf", 6, 1, 64'h1_8000_0000, 64'hFFFF_FFFF, 64'd0, 1, 0));
        vecs.push_back(mk("divuw_z", 5, 1, 64'h8000_0001, 64'h1_0000_0000, '1, 1, 0));
        vecs.push_back(mk("remuw_z", 7, 1, 64'h8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0001, 1, 0));
        vecs.push_back(mk("slow_div_z", 4, 0, 64'd5, 64'd0, '1, 64, 1));
        vecs.push_back(mk("slow_divneg_z", 4, 0, -64'sd7, 64'd0, '1, 64, 1));
        vecs.push_back(mk("slow_remneg_z", 6, 0, -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64, 1));
        vecs.push_back(mk("slow_div_ovf", 4, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64, 1));
        vecs.push_back(mk("slow_rem_ovf", 6, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 64, 1));
        vecs.push_back(mk("slow_remuw_z", 7, 1, 64'h8000_0001, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0001, 32, 1));

        for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        do_op(mk("bp_divu", 5, 0, 64'd100, 64'd7, 64'd14, 64, 0));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 64'(ov), 64'd1);
            chk("bp_in_ready", 64'(rdy), 64'd0);
            chk("bp_result", res, 64'd14);
        end
        // Flush and out_ready together in DONE: flush wins, result dropped
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_done_out_valid", 64'(ov), 64'd0);
        chk("flush_done_in_ready", 64'(rdy), 64'd1);
        @(negedge clk);
        flush = 1'b0;

        // Flush mid-multiply
        op = 3'd0; word = 1'b0; a = 64'd3; b = 64'd5; in_valid_f = 1'b1;
        @(posedge clk);
        #1;
        in_valid_f = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_iter_in_ready", 64'(rdy), 64'd1);
        chk("flush_iter_busy", 64'(bsy), 64'd0);
        chk("flush_iter_out_valid", 64'(ov), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (ov) seen = 1'b1;
        end
        chk("flush_iter_no_result", 64'(seen), 64'd0);

        // Request presented on a flush cycle is ignored
        @(negedge clk);
        op = 3'd4; a = 64'd9; b = 64'd3; in_valid_f = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_accept_in_ready", 64'(rdy), 64'd1);
        chk("flush_accept_busy", 64'(bsy), 64'd0);
        in_valid_f = 1'b0;
        flush = 1'b0;

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        op = 3'd4; a = 64'd100; b = 64'd3; in_valid_f = 1'b1;
        @(posedge clk);
        #1;
        in_valid_f = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        chk("pre_reset_busy", 64'(bsy), 64'd1);
        resetn = 1'b0;
        #1;
        chk("async_in_ready", 64'(rdy), 64'd1);
        chk("async_busy", 64'(bsy), 64'd0);
        chk("async_out_valid", 64'(ov), 64'd0);
        chk("async_result", res, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        do_op(mk("post_reset_mulw", 0, 1, 64'h8000_0000, 64'd2, 64'd0, 32, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
